sprite_hshrink_writer: RTL and testbench
========================================

# sprite_hshrink_writer

Downstream consumer of the fast-cycle sprite parameter pipeline. Takes the per-sprite `{chain, h-shrink, X}` word that leaves the 3-stage parameter pipeline, and resolves chained X positions. It then emits 16 source pixels per sprite through a horizontal shrink decimator and drives line-buffer write address, data and strobe, one kept opaque pixel per pixel slot.

## Interface
Parameters: none.

Ports:
- `CLK_24M`  in  1  master clock; all state on rising edge.
- `RESETP`  in  1  asynchronous, active-high reset.
- `PIX_CE`  in  1  pixel-slot clock enable, one `CLK_24M` cycle wide (12 MHz rate).
- `NEW_LINE`  in  1  one-cycle pulse at line start; invalidates chain base.
- `LOAD`  in  1  one-cycle strobe: `PIPE_C` valid, start a sprite.
- `PIPE_C`  in  14  `{[13] chain, [12:9] hshrink, [8:0] xpos}`.
- `PAL`  in  8  palette number for the sprite, sampled with `LOAD`.
- `PIX_COLOR`  in  4  colour index of current source pixel, valid on `PIX_CE` while `BUSY`.
- `PIX_REQ`  out  1  source pixel consumed this cycle (`= BUSY & PIX_CE`).
- `BUSY`  out  1  sprite in progress.
- `LB_ADDR`  out  9  line-buffer write address.
- `LB_DATA`  out  12  `{PAL, colour}`.
- `LB_WE`  out  1  one-cycle write strobe.

## Operation
- **States:** `IDLE`, `DRAW`. `PIX_CNT[3:0]`, `ACC[3:0]`, `X_CUR[8:0]`, `NEXT_X[8:0]`, `CHAIN_VALID`.
- **`LOAD` accept (any state):**
  - Latch shrink `S`, `PAL`.
  - `X_CUR` = `NEXT_X` if `chain & CHAIN_VALID`, else `xpos`.
  - `NEXT_X` ← that base + `S` + 1 (mod 512).
  - `CHAIN_VALID` ← 1.
  - `PIX_CNT` ← 0, `ACC` ← 0, state ← `DRAW`.
- **Each `PIX_CE` in `DRAW`:**
  - `SUM` = `ACC` + `S` + 1 (5 bits).
  - Pixel kept iff `SUM[4]`; `ACC` ← `SUM[3:0]`.
  - If kept and `PIX_COLOR` != 0: `LB_WE` = 1, `LB_ADDR` = `X_CUR`, `LB_DATA` = `{PAL, PIX_COLOR}`.
  - If kept (opaque or not): `X_CUR` += 1 mod 512.
  - `PIX_CNT` += 1. At `PIX_CNT` = 15 → `IDLE`.
- **Kept pixel count:** exactly `S`+1 per sprite. `S` = 15 keeps all 16. `S` = 0 keeps only source pixel 15.
- **`LOAD` during `DRAW`:** current sprite abandoned with no further writes; new sprite starts per the `LOAD` rule. `NEXT_X` already reflects the abandoned sprite's full width, so chaining is unaffected.
- **`NEW_LINE`:** `CHAIN_VALID` ← 0; does not abort `DRAW`.
- **`NEW_LINE` and `LOAD` in the same cycle:** `NEW_LINE` applies first, so a chained sprite uses its own `xpos`.
- **`LOAD` and `PIX_CE` in the same cycle:** the load wins; no pixel is processed for either sprite that cycle.
- **X wrap:** 511 → 0, writes continue.

## Timing
- **Reset values:** `BUSY`=0, `LB_WE`=0, `LB_ADDR`=0, `LB_DATA`=0, `PIX_REQ`=0, `CHAIN_VALID`=0, `NEXT_X`=0, `ACC`=0, `PIX_CNT`=0. Reset mid-sprite aborts immediately.
- `BUSY` rises the cycle after `LOAD` and falls the cycle after the 16th `PIX_CE`.
- `PIX_REQ` is combinational.
- `LB_WE`, `LB_ADDR` and `LB_DATA` are registered: valid one `CLK_24M` cycle after the consuming `PIX_CE`, held between strobes, `LB_WE` high for exactly one cycle.
- Sprite duration is 16 `PIX_CE` pulses (32 `CLK_24M` cycles at nominal rate).
- Throughput: back-to-back `LOAD` on the cycle `BUSY` falls gives no gap.

## Test plan
- **Full width:** reset; `LOAD` with `PIPE_C`=`{0,4'hF,9'd100}`, `PAL`=8'h12, colours 1..15,1 → 16 writes, addr 100..115, data 12'h121..12'h12F, then 12'h121. `BUSY` low after the 16th `PIX_CE`.
- **Shrink 7, with a transparent pixel:** `S`=7, X=200, colour 0 on source pixel 1, others 5 → kept source pixels 1,3,5,…,15 (8 kept). Pixel 1 writes nothing but consumes addr 200; 7 writes at addr 201..207.
- **Chain:** sprite A X=300, `S`=3. Then sprite B with chain=1, xpos=9'd0 → B writes start at 304. After `NEW_LINE`, a chained sprite with xpos=50 starts at 50.
- **Wrap:** X=508, `S`=15, all opaque → addrs 508..511, 0..11.
- **Abort:** `LOAD` on X=10 `S`=15, then re-`LOAD` after 5 `PIX_CE` with a chained sprite → no more writes at addr ≥15. The new sprite starts at 26.
- **Reset mid-sprite:** assert `RESETP` at pixel 8 → all outputs 0 in the same cycle. A chained `LOAD` after release uses its own xpos.

Source files
------------

// File: rtl/sprite_hshrink_writer.sv
// Chained-X sprite writer: shrink-decimates 16 source pixels per sprite into line-buffer writes; LB_* are registered one cycle after the consuming PIX_CE.
// No backpressure: the source is paced by PIX_CE, and a LOAD always aborts the sprite in progress and restarts.
module sprite_hshrink_writer (
    input  logic        CLK_24M,
    input  logic        RESETP,
    input  logic        PIX_CE,
    input  logic        NEW_LINE,
    input  logic        LOAD,
    input  logic [13:0] PIPE_C,
    input  logic [7:0]  PAL,
    input  logic [3:0]  PIX_COLOR,
    output logic        PIX_REQ,
    output logic        BUSY,
    output logic [8:0]  LB_ADDR,
    output logic [11:0] LB_DATA,
    output logic        LB_WE
);

    typedef enum logic {ST_IDLE, ST_DRAW} state_t;

    state_t      state_q, state_d;
    logic [3:0]  pix_cnt_q, pix_cnt_d;
    logic [3:0]  acc_q, acc_d;
    logic [3:0]  shrink_q, shrink_d;
    logic [7:0]  pal_q, pal_d;
    logic [8:0]  x_cur_q, x_cur_d;
    logic [8:0]  next_x_q, next_x_d;
    logic        chain_valid_q, chain_valid_d;
    logic        lb_we_q, lb_we_d;
    logic [8:0]  lb_addr_q, lb_addr_d;
    logic [11:0] lb_data_q, lb_data_d;

    logic        load_chain;
    logic [8:0]  load_base;
    logic [4:0]  sum;

    // NEW_LINE in the same cycle as LOAD must already kill the chain base.
    assign load_chain = PIPE_C[13] & chain_valid_q & ~NEW_LINE;
    assign load_base  = load_chain ? next_x_q : PIPE_C[8:0];
    assign sum        = {1'b0, acc_q} + {1'b0, shrink_q} + 5'd1;

    always_comb begin
        state_d       = state_q;
        pix_cnt_d     = pix_cnt_q;
        acc_d         = acc_q;
        shrink_d      = shrink_q;
        pal_d         = pal_q;
        x_cur_d       = x_cur_q;
        next_x_d      = next_x_q;
        chain_valid_d = chain_valid_q;
        lb_we_d       = 1'b0;
        lb_addr_d     = lb_addr_q;
        lb_data_d     = lb_data_q;

        if (NEW_LINE) begin
            chain_valid_d = 1'b0;
        end

        if (LOAD) begin
            shrink_d      = PIPE_C[12:9];
            pal_d         = PAL;
            x_cur_d       = load_base;
            next_x_d      = load_base + {5'd0, PIPE_C[12:9]} + 9'd1;
            chain_valid_d = 1'b1;
            pix_cnt_d     = 4'd0;
            acc_d         = 4'd0;
            state_d       = ST_DRAW;
        end else if (state_q == ST_DRAW && PIX_CE) begin
            acc_d     = sum[3:0];
            pix_cnt_d = pix_cnt_q + 4'd1;
            if (sum[4]) begin
                // Transparent kept pixels still advance X.
                x_cur_d = x_cur_q + 9'd1;
                if (PIX_COLOR != 4'd0) begin
                    lb_we_d   = 1'b1;
                    lb_addr_d = x_cur_q;
                    lb_data_d = {pal_q, PIX_COLOR};
                end
            end
            if (pix_cnt_q == 4'd15) begin
                state_d = ST_IDLE;
            end
        end
    end

    always_ff @(posedge CLK_24M or posedge RESETP) begin
        if (RESETP) begin
            state_q       <= ST_IDLE;
            pix_cnt_q     <= 4'd0;
            acc_q         <= 4'd0;
            shrink_q      <= 4'd0;
            pal_q         <= 8'd0;
            x_cur_q       <= 9'd0;
            next_x_q      <= 9'd0;
            chain_valid_q <= 1'b0;
            lb_we_q       <= 1'b0;
            lb_addr_q     <= 9'd0;
            lb_data_q     <= 12'd0;
        end else begin
            state_q       <= state_d;
            pix_cnt_q     <= pix_cnt_d;
            acc_q         <= acc_d;
            shrink_q      <= shrink_d;
            pal_q         <= pal_d;
            x_cur_q       <= x_cur_d;
            next_x_q      <= next_x_d;
            chain_valid_q <= chain_valid_d;
            lb_we_q       <= lb_we_d;
            lb_addr_q     <= lb_addr_d;
            lb_data_q     <= lb_data_d;
        end
    end

    assign BUSY    = (state_q == ST_DRAW);
    assign PIX_REQ = BUSY & PIX_CE;
    assign LB_WE   = lb_we_q;
    assign LB_ADDR = lb_addr_q;
    assign LB_DATA = lb_data_q;

endmodule

// File: tb/tb_sprite_hshrink_writer.sv
// Scoreboard bench for sprite_hshrink_writer: directed sprites push expected {addr,data} writes; a negedge monitor pops and compares every LB_WE strobe.
module tb_sprite_hshrink_writer;

    logic        CLK_24M = 1'b0;
    logic        RESETP;
    logic        PIX_CE;
    logic        NEW_LINE;
    logic        LOAD;
    logic [13:0] PIPE_C;
    logic [7:0]  PAL;
    logic [3:0]  PIX_COLOR;
    logic        PIX_REQ;
    logic        BUSY;
    logic [8:0]  LB_ADDR;
    logic [11:0] LB_DATA;
    logic        LB_WE;

    int errors = 0;
    int checks = 0;
    logic [20:0] exp_q[$];

    sprite_hshrink_writer dut (
        .CLK_24M  (CLK_24M),
        .RESETP   (RESETP),
        .PIX_CE   (PIX_CE),
        .NEW_LINE (NEW_LINE),
        .LOAD     (LOAD),
        .PIPE_C   (PIPE_C),
        .PAL      (PAL),
        .PIX_COLOR(PIX_COLOR),
        .PIX_REQ  (PIX_REQ),
        .BUSY     (BUSY),
        .LB_ADDR  (LB_ADDR),
        .LB_DATA  (LB_DATA),
        .LB_WE    (LB_WE)
    );

    always #5 CLK_24M = ~CLK_24M;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic push(input int addr, input logic [7:0] p, input logic [3:0] c);
        logic [8:0] a;
        a = addr[8:0];
        exp_q.push_back({a, p, c});
    endtask

    // Monitor: every strobe must match the head of the scoreboard.
    always @(negedge CLK_24M) begin
        if (!RESETP && LB_WE) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write_addr", int'(LB_ADDR), -1);
            end else begin
                logic [20:0] e;
                e = exp_q.pop_front();
                chk("write_addr", int'(LB_ADDR), int'(e[20:12]));
                chk("write_data", int'(LB_DATA), int'(e[11:0]));
            end
        end
    end

    task automatic cyc();
        @(posedge CLK_24M);
        #1;
    endtask

    task automatic do_load(input logic ch, input logic [3:0] s, input logic [8:0] x,
                           input logic [7:0] p, input logic nl);
        LOAD     = 1'b1;
        NEW_LINE = nl;
        PIPE_C   = {ch, s, x};
        PAL      = p;
        cyc();
        LOAD     = 1'b0;
        NEW_LINE = 1'b0;
        chk("busy_after_load", int'(BUSY), 1);
    endtask

    // One nominal-rate pixel slot: PIX_CE for one cycle, then one idle cycle.
    task automatic pix(input logic [3:0] c);
        PIX_CE    = 1'b1;
        PIX_COLOR = c;
        cyc();
        PIX_CE    = 1'b0;
        cyc();
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 50; i++) begin
            if (exp_q.size() == 0) break;
            cyc();
        end
        chk(name, exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        RESETP    = 1'b1;
        PIX_CE    = 1'b0;
        NEW_LINE  = 1'b0;
        LOAD      = 1'b0;
        PIPE_C    = 14'd0;
        PAL       = 8'd0;
        PIX_COLOR = 4'd0;
        #12;
        chk("rst_busy", int'(BUSY), 0);
        chk("rst_we", int'(LB_WE), 0);
        chk("rst_addr", int'(LB_ADDR), 0);
        chk("rst_data", int'(LB_DATA), 0);
        chk("rst_pix_req", int'(PIX_REQ), 0);
        cyc();
        RESETP = 1'b0;
        cyc();

        // Full width: colours 1..15 then 1, addrs 100..115.
        for (int i = 0; i < 16; i++) push(100 + i, 8'h12, (i < 15) ? 4'(i + 1) : 4'd1);
        do_load(1'b0, 4'hF, 9'd100, 8'h12, 1'b0);
        for (int i = 0; i < 16; i++) begin
            PIX_CE    = 1'b1;
            PIX_COLOR = (i < 15) ? 4'(i + 1) : 4'd1;
            #1;
            if (i == 0) chk("pix_req", int'(PIX_REQ), 1);
            cyc();
            PIX_CE = 1'b0;
            if (i == 14) chk("busy_before_last", int'(BUSY), 1);
            if (i == 15) chk("busy_fall", int'(BUSY), 0);
            cyc();
        end
        chk("pix_req_idle", int'(PIX_REQ), 0);
        drain("full_width_drain");

        // Shrink 7: kept 1,3..15; pixel 1 transparent consumes addr 200.
        for (int i = 0; i < 7; i++) push(201 + i, 8'h34, 4'd5);
        do_load(1'b0, 4'd7, 9'd200, 8'h34, 1'b0);
        for (int i = 0; i < 16; i++) pix((i == 1) ? 4'd0 : 4'd5);
        drain("shrink7_drain");

        // Chain: A at 300 S=3 (kept 4), B chained -> 304.
        for (int i = 0; i < 4; i++) push(300 + i, 8'h56, 4'd7);
        do_load(1'b0, 4'd3, 9'd300, 8'h56, 1'b0);
        for (int i = 0; i < 16; i++) pix(4'd7);
        drain("chain_a_drain");
        for (int i = 0; i < 4; i++) push(304 + i, 8'h57, 4'd8);
        do_load(1'b1, 4'd3, 9'd0, 8'h57, 1'b0);
        for (int i = 0; i < 16; i++) pix(4'd8);
        drain("chain_b_drain");
        // NEW_LINE, then chained S=0 at 50: only source pixel 15 kept.
        NEW_LINE = 1'b1;
        cyc();
        NEW_LINE = 1'b0;
        push(50, 8'h58, 4'd9);
        do_load(1'b1, 4'd0, 9'd50, 8'h58, 1'b0);
        for (int i = 0; i < 16; i++) pix((i == 15) ? 4'd9 : 4'd2);
        drain("chain_newline_drain");
        // NEW_LINE coincident with chained LOAD: own xpos 70.
        push(70, 8'h59, 4'd3);
        do_load(1'b1, 4'd0, 9'd70, 8'h59, 1'b1);
        for (int i = 0; i < 16; i++) pix((i == 15) ? 4'd3 : 4'd1);
        drain("newline_load_drain");

        // Wrap: 508..511, 0..11.
        for (int i = 0; i < 16; i++) push((i < 4) ? 508 + i : i - 4, 8'h9A, 4'd3);
        do_load(1'b0, 4'hF, 9'd508, 8'h9A, 1'b0);
        for (int i = 0; i < 16; i++) pix(4'd3);
        drain("wrap_drain");

        // Abort after 5 pixels; re-LOAD coincides with PIX_CE (load wins).
        for (int i = 0; i < 5; i++) push(10 + i, 8'hBC, 4'd4);
        for (int i = 0; i < 16; i++) push(26 + i, 8'hBD, 4'd6);
        do_load(1'b0, 4'hF, 9'd10, 8'hBC, 1'b0);
        for (int i = 0; i < 5; i++) pix(4'd4);
        PIX_CE    = 1'b1;
        PIX_COLOR = 4'hF;
        do_load(1'b1, 4'hF, 9'd0, 8'hBD, 1'b0);
        PIX_CE = 1'b0;
        cyc();
        for (int i = 0; i < 16; i++) pix(4'd6);
        drain("abort_drain");

        // Reset at pixel 8 clears outputs immediately; chain base is lost.
        for (int i = 0; i < 8; i++) push(400 + i, 8'hDE, 4'd2);
        do_load(1'b0, 4'hF, 9'd400, 8'hDE, 1'b0);
        for (int i = 0; i < 8; i++) pix(4'd2);
        drain("pre_reset_drain");
        PIX_CE    = 1'b1;
        PIX_COLOR = 4'd2;
        #1;
        RESETP = 1'b1;
        #1;
        chk("midrst_busy", int'(BUSY), 0);
        chk("midrst_pix_req", int'(PIX_REQ), 0);
        chk("midrst_we", int'(LB_WE), 0);
        chk("midrst_addr", int'(LB_ADDR), 0);
        chk("midrst_data", int'(LB_DATA), 0);
        PIX_CE = 1'b0;
        cyc();
        RESETP = 1'b0;
        cyc();
        push(60, 8'h11, 4'd1);
        push(61, 8'h11, 4'd1);
        do_load(1'b1, 4'hF, 9'd60, 8'h11, 1'b0);
        pix(4'd1);
        pix(4'd1);
        drain("post_reset_drain");
        repeat (4) cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
